// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control unit for a shared MIPS-style datapath.
// Optional MCU_PERF_CNT_EN adds retired-instruction and handshake-stall counters.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        zero,
    output logic        imem_req,
    output logic        dmem_req,
    output logic [2:0]  alu_ctrl,
    output logic        rf_we,
    output logic        sel_alu_b,
    output logic [1:0]  sel_pc,
    output logic        sel_result,
    output logic        sel_wa,
    output logic        dmem_we,
    output logic        branch,
    output logic        ir_we,
    output logic        pc_we,
    output logic        illegal
`ifdef MCU_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

    state_e     state_q;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    // Clear during reset so every output is held low until the first cycle after release.
    logic       active_q;

    logic       legal;
    logic [2:0] alu_r;
    logic       is_r, is_addi, is_lw, is_sw, is_beq, is_j;

    assign is_r    = (op_q == OpRtype);
    assign is_addi = (op_q == OpAddi);
    assign is_lw   = (op_q == OpLw);
    assign is_sw   = (op_q == OpSw);
    assign is_beq  = (op_q == OpBeq);
    assign is_j    = (op_q == OpJ);

    always_comb begin
        legal = 1'b0;
        alu_r = AluAdd;
        case (op_q)
            OpRtype: begin
                case (funct_q)
                    FnAdd:   begin legal = 1'b1; alu_r = AluAdd; end
                    FnSub:   begin legal = 1'b1; alu_r = AluSub; end
                    FnAnd:   begin legal = 1'b1; alu_r = AluAnd; end
                    FnOr:    begin legal = 1'b1; alu_r = AluOr;  end
                    FnSlt:   begin legal = 1'b1; alu_r = AluSlt; end
                    default: legal = 1'b0;
                endcase
            end
            OpAddi, OpLw, OpSw, OpBeq, OpJ: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        alu_ctrl   = 3'b000;
        rf_we      = 1'b0;
        sel_alu_b  = 1'b0;
        sel_pc     = 2'd0;
        sel_result = 1'b0;
        sel_wa     = 1'b0;
        dmem_we    = 1'b0;
        branch     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        illegal    = 1'b0;
        if (active_q) begin
            // No ALU output register: operand selects stay valid from EXEC through WB.
            if (state_q == StExec || state_q == StMem || state_q == StWb) begin
                if (is_r) begin
                    alu_ctrl = alu_r;
                end else if (is_addi || is_lw || is_sw) begin
                    alu_ctrl  = AluAdd;
                    sel_alu_b = 1'b1;
                end
            end
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                StDecode: begin
                    if (!legal) begin
                        illegal = 1'b1;
                        pc_we   = 1'b1;
                    end
                end
                StExec: begin
                    if (is_beq) begin
                        alu_ctrl = AluSub;
                        branch   = 1'b1;
                        pc_we    = 1'b1;
                        sel_pc   = {1'b0, zero};
                    end else if (is_j) begin
                        pc_we  = 1'b1;
                        sel_pc = 2'd2;
                    end
                end
                StMem: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_sw;
                    pc_we    = is_sw && dmem_ack;
                end
                StWb: begin
                    rf_we      = 1'b1;
                    pc_we      = 1'b1;
                    sel_wa     = is_r;
                    sel_result = is_lw;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            op_q     <= 6'd0;
            funct_q  <= 6'd0;
            active_q <= 1'b0;
`ifdef MCU_PERF_CNT_EN
            retired_cnt <= 32'd0;
            stall_cnt   <= 32'd0;
`endif
        end else begin
            active_q <= 1'b1;
            if (active_q) begin
                case (state_q)
                    StFetch: begin
                        if (imem_ack) begin
                            op_q    <= instr[31:26];
                            funct_q <= instr[5:0];
                            state_q <= StDecode;
                        end
                    end
                    StDecode: state_q <= legal ? StExec : StFetch;
                    StExec: begin
                        if (is_r || is_addi)    state_q <= StWb;
                        else if (is_lw || is_sw) state_q <= StMem;
                        else                     state_q <= StFetch;
                    end
                    StMem: begin
                        if (dmem_ack) state_q <= is_lw ? StWb : StFetch;
                    end
                    StWb:    state_q <= StFetch;
                    default: state_q <= StFetch;
                endcase
            end
`ifdef MCU_PERF_CNT_EN
            if (pc_we && !illegal) retired_cnt <= retired_cnt + 32'd1;
            if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (perf counters when MCU_PERF_CNT_EN).
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_ack, dmem_ack, zero;
    logic        imem_req, dmem_req, rf_we, sel_alu_b, sel_result, sel_wa;
    logic        dmem_we, branch, ir_we, pc_we, illegal;
    logic [2:0]  alu_ctrl;
    logic [1:0]  sel_pc;
`ifdef MCU_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .zero       (zero),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .alu_ctrl   (alu_ctrl),
        .rf_we      (rf_we),
        .sel_alu_b  (sel_alu_b),
        .sel_pc     (sel_pc),
        .sel_result (sel_result),
        .sel_wa     (sel_wa),
        .dmem_we    (dmem_we),
        .branch     (branch),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .illegal    (illegal)
`ifdef MCU_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [17:0] all_out;
    assign all_out = {imem_req, dmem_req, alu_ctrl, rf_we, sel_alu_b, sel_pc, sel_result,
                      sel_wa, dmem_we, branch, ir_we, pc_we, illegal, 2'b00};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0; instr = 32'd0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Drives one instruction from its FETCH cycle until the pc_we cycle; no checking here.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic z,
                             output int cycles, output int n_rf, output int n_pc,
                             output int n_ill, output int n_st);
        int ic, dc;
        bit done;
        ic = 0; dc = 0; done = 0;
        cycles = 0; n_rf = 0; n_pc = 0; n_ill = 0; n_st = 0;
        instr = ins; zero = z;
        for (int k = 0; k < 40 && !done; k++) begin
            imem_ack = imem_req && (ic == iw);
            dmem_ack = dmem_req && (dc == dw);
            if (imem_req) ic++;
            if (dmem_req) dc++;
            #1;
            cycles++;
            n_rf  += int'(rf_we);
            n_pc  += int'(pc_we);
            n_ill += int'(illegal);
            n_st  += int'(dmem_req && dmem_we && dmem_ack);
            if (pc_we) done = 1;
            step();
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        if (!done) cycles = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0; instr = 32'd0;
        step(); step(); step();
        n_checks++;
        if (all_out !== 18'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
`ifdef MCU_PERF_CNT_EN
        n_checks++;
        if (retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", retired_cnt, stall_cnt);
        end
`endif
        rst_n = 1'b1; #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_req: got %b want 0", imem_req);
        end
        step();
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++; $display("FAIL reset_first_req: got %b want 1", imem_req);
        end
    endtask

    task automatic test_add();
        reset_dut();
        n_checks++;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL add_c1_req: got %b want 1", imem_req); end
        instr = 32'h00221820; imem_ack = 1'b1; #1;
        n_checks++;
        if (ir_we !== 1'b1) begin n_fail++; $display("FAIL add_c1_ir_we: got %b want 1", ir_we); end
        step(); imem_ack = 1'b0; #1;
        n_checks++;
        if ({imem_req, rf_we, pc_we, dmem_req, illegal} !== 5'b0) begin
            n_fail++; $display("FAIL add_c2_decode: got %b want 00000", {imem_req, rf_we, pc_we, dmem_req, illegal});
        end
        step();
        n_checks++;
        if (alu_ctrl !== 3'b010 || sel_alu_b !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL add_c3_exec: got alu=%b b=%b we=%b want 010 0 0", alu_ctrl, sel_alu_b, rf_we);
        end
        step();
        n_checks++;
        if ({rf_we, sel_wa, sel_result, pc_we, sel_pc, alu_ctrl} !== 9'b1101_00_010) begin
            n_fail++; $display("FAIL add_c4_wb: got %b want 110100010", {rf_we, sel_wa, sel_result, pc_we, sel_pc, alu_ctrl});
        end
        step();
        n_checks++;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL add_c5_fetch: got %b want 1", imem_req); end
    endtask

    task automatic test_lw_wait();
        int nreq;
        nreq = 0;
        instr = 32'h8C220004; imem_ack = 1'b1; #1;
        step(); imem_ack = 1'b0;
        step(); #1;
        n_checks++;
        if (sel_alu_b !== 1'b1 || alu_ctrl !== 3'b010) begin
            n_fail++; $display("FAIL lw_exec: got b=%b alu=%b want 1 010", sel_alu_b, alu_ctrl);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            if (dmem_req) nreq++;
            n_checks++;
            if (dmem_we !== 1'b0 || pc_we !== 1'b0 || rf_we !== 1'b0) begin
                n_fail++; $display("FAIL lw_mem_wait%0d: got we=%b pc=%b rf=%b want 0 0 0", k, dmem_we, pc_we, rf_we);
            end
            step();
        end
        dmem_ack = 1'b1; #1;
        if (dmem_req) nreq++;
        step(); dmem_ack = 1'b0; #1;
        n_checks++;
        if (nreq !== 4) begin n_fail++; $display("FAIL lw_req_cycles: got %0d want 4", nreq); end
        n_checks++;
        if ({rf_we, sel_result, sel_wa, pc_we, sel_pc} !== 6'b1101_00) begin
            n_fail++; $display("FAIL lw_wb: got %b want 110100", {rf_we, sel_result, sel_wa, pc_we, sel_pc});
        end
        step();
        n_checks++;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL lw_next_fetch: got %b want 1", imem_req); end
    endtask

    task automatic test_beq();
        logic zs [2];
        zs[0] = 1'b1; zs[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            instr = 32'h10220003; imem_ack = 1'b1; #1;
            step(); imem_ack = 1'b0;
            step(); zero = zs[k]; #1;
            n_checks++;
            if ({branch, pc_we, sel_pc, alu_ctrl} !== {2'b11, 1'b0, zs[k], 3'b110}) begin
                n_fail++; $display("FAIL beq_exec_z%0d: got %b want %b", zs[k], {branch, pc_we, sel_pc, alu_ctrl}, {2'b11, 1'b0, zs[k], 3'b110});
            end
            step(); zero = 1'b0; #1;
            n_checks++;
            if (imem_req !== 1'b1 || branch !== 1'b0) begin
                n_fail++; $display("FAIL beq_next_fetch_z%0d: got req=%b br=%b want 1 0", zs[k], imem_req, branch);
            end
        end
    endtask

    task automatic test_illegal();
        reset_dut();
        instr = 32'hFC000000; imem_ack = 1'b1; #1;
        step(); imem_ack = 1'b0; #1;
        n_checks++;
        if ({illegal, pc_we, sel_pc, rf_we, dmem_we} !== 6'b11_00_00) begin
            n_fail++; $display("FAIL illegal_decode: got %b want 110000", {illegal, pc_we, sel_pc, rf_we, dmem_we});
        end
        step();
        n_checks++;
        if (illegal !== 1'b0 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL illegal_after: got ill=%b req=%b want 0 1", illegal, imem_req);
        end
`ifdef MCU_PERF_CNT_EN
        n_checks++;
        if (retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL illegal_retired: got %0d want 0", retired_cnt);
        end
`endif
    endtask

    task automatic test_sw_reset();
        instr = 32'hAC220008; imem_ack = 1'b1; #1;
        step(); imem_ack = 1'b0;
        step(); step(); #1;
        n_checks++;
        if ({dmem_req, dmem_we, pc_we} !== 3'b110) begin
            n_fail++; $display("FAIL sw_mem: got %b want 110", {dmem_req, dmem_we, pc_we});
        end
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({dmem_req, dmem_we, pc_we, rf_we, imem_req} !== 5'b0) begin
            n_fail++; $display("FAIL sw_abort: got %b want 00000", {dmem_req, dmem_we, pc_we, rf_we, imem_req});
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL sw_refetch: got req=%b dreq=%b want 1 0", imem_req, dmem_req);
        end
    endtask

    task automatic test_cycle_counts();
        logic [31:0] ins [10];
        int iw [10], dw [10], cyc [10], rf [10], ill [10], st [10];
        int c, nr, np, ni, ns;
        ins = '{32'h00221820, 32'h20220005, 32'h8C220004, 32'hAC220008, 32'h10220003,
                32'h08000010, 32'hFC000000, 32'h00221821, 32'h00221820, 32'h8C220004};
        iw  = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 1};
        dw  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
        cyc = '{4, 4, 5, 4, 3, 3, 2, 2, 6, 8};
        rf  = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        ill = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        st  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        reset_dut();
        for (int k = 0; k < 10; k++) begin
            run_instr(ins[k], iw[k], dw[k], 1'b0, c, nr, np, ni, ns);
            n_checks++;
            if (c !== cyc[k]) begin
                n_fail++; $display("FAIL cycles_%0d (%h): got %0d want %0d", k, ins[k], c, cyc[k]);
            end
            n_checks++;
            if (nr !== rf[k] || np !== 1 || ni !== ill[k] || ns !== st[k]) begin
                n_fail++; $display("FAIL strobes_%0d (%h): got rf=%0d pc=%0d ill=%0d st=%0d want %0d 1 %0d %0d",
                                   k, ins[k], nr, np, ni, ns, rf[k], ill[k], st[k]);
            end
        end
    endtask

`ifdef MCU_PERF_CNT_EN
    task automatic test_perf();
        int c, nr, np, ni, ns;
        reset_dut();
        run_instr(32'h00221820, 1, 0, 1'b0, c, nr, np, ni, ns);
        run_instr(32'h20220005, 1, 0, 1'b0, c, nr, np, ni, ns);
        run_instr(32'h08000010, 0, 0, 1'b0, c, nr, np, ni, ns);
        run_instr(32'h10220003, 0, 0, 1'b0, c, nr, np, ni, ns);
        run_instr(32'hAC220008, 0, 0, 1'b0, c, nr, np, ni, ns);
        n_checks++;
        if (retired_cnt !== 32'd5) begin
            n_fail++; $display("FAIL perf_retired: got %0d want 5", retired_cnt);
        end
        n_checks++;
        if (stall_cnt !== 32'd2) begin
            n_fail++; $display("FAIL perf_stall: got %0d want 2", stall_cnt);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_sw_reset();
        test_cycle_counts();
`ifdef MCU_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
